// File: rtl/window_3x3_gen.sv
// window_3x3_gen: turns a raster RGB444 pixel stream into one 3x3 neighbourhood
// word per pixel (centre first), using two line buffers and a 3x3 register window.
// Optional macro BORDER_REPLICATE_EN: out-of-image neighbours take the nearest
// in-image pixel; without it they read as 12'h000.
module window_3x3_gen #(
    parameter int IMG_W = 160,
    parameter int IMG_H = 120
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [11:0]  pix_in,
    input  logic         pix_valid,
    input  logic         frame_start,
    output logic         pix_ready,
    output logic [107:0] color_data,
    output logic         window_valid,
    output logic [7:0]   win_x,
    output logic [7:0]   win_y
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    state_t state, state_nxt;

    // lb_a holds the line above the incoming pixel, lb_b the line above that
    logic [11:0] lb_a [IMG_W];
    logic [11:0] lb_b [IMG_W];

    // window[row][col], row 0 = top, col 0 = left; col 2 is the newest column
    logic [2:0][2:0][11:0] win_q;
    logic [2:0][2:0][11:0] nwin;

    logic [XW-1:0] in_x, c_x, step_x;
    logic [YW-1:0] in_y, c_y;
    logic          accept, restart, flushing, step, emit;
    logic          at_l, at_r, at_t, at_b;
    logic [11:0]   new_pix;

    // Substitute out-of-image neighbours and pack into the filter word layout.
    function automatic logic [107:0] border_fix(input logic [2:0][2:0][11:0] w,
                                                input logic l, input logic r,
                                                input logic t, input logic b);
        logic [2:0][2:0][11:0] f;
        f = w;
`ifdef BORDER_REPLICATE_EN
        // Columns first, then rows, so corners collapse onto the centre pixel.
        for (int i = 0; i < 3; i++) begin
            if (l) f[i][0] = f[i][1];
            if (r) f[i][2] = f[i][1];
        end
        for (int i = 0; i < 3; i++) begin
            if (t) f[0][i] = f[1][i];
            if (b) f[2][i] = f[1][i];
        end
`else
        for (int i = 0; i < 3; i++) begin
            if (l) f[i][0] = 12'h000;
            if (r) f[i][2] = 12'h000;
            if (t) f[0][i] = 12'h000;
            if (b) f[2][i] = 12'h000;
        end
`endif
        return {f[1][1], f[1][0], f[1][2], f[0][1], f[2][1],
                f[0][0], f[0][2], f[2][0], f[2][2]};
    endfunction

    // Handshake decode, next window contents and border flags of the emitted centre
    always_comb begin
        accept   = pix_valid & pix_ready;
        restart  = accept & frame_start;
        flushing = (state == FLUSH);
        // FLUSH keeps stepping with a dummy pixel; its column only feeds masked positions.
        step     = restart | (accept & (state != IDLE)) | flushing;
        emit     = (accept & ~frame_start & (state == RUN)) | flushing;
        step_x   = restart ? '0 : in_x;
        new_pix  = flushing ? 12'h000 : pix_in;
        nwin     = '0;
        for (int i = 0; i < 3; i++) begin
            nwin[i][0] = win_q[i][1];
            nwin[i][1] = win_q[i][2];
        end
        nwin[0][2] = lb_b[step_x];
        nwin[1][2] = lb_a[step_x];
        nwin[2][2] = new_pix;
        at_l = (c_x == '0);
        at_r = (c_x == X_LAST);
        at_t = (c_y == '0);
        at_b = (c_y == Y_LAST);
    end

    // Frame sequencing: wait for frame start, prime two lines, stream, drain
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (restart) state_nxt = FILL;
            FILL:  if (restart) state_nxt = FILL;
                   else if (accept && in_x == '0 && in_y == Y_ONE) state_nxt = RUN;
            RUN:   if (restart) state_nxt = FILL;
                   else if (accept && in_x == X_LAST && in_y == Y_LAST) state_nxt = FLUSH;
            FLUSH: if (c_x == X_LAST && c_y == Y_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Ready is low for exactly the FLUSH cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pix_ready <= 1'b0;
        else       pix_ready <= (state_nxt != FLUSH);
    end

    // Input position (next pixel to arrive) and centre position (next window to emit)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_x <= '0;
            in_y <= '0;
            c_x  <= '0;
            c_y  <= '0;
        end else begin
            if (restart) begin
                in_x <= X_ONE;
                in_y <= '0;
            end else if (step) begin
                if (in_x == X_LAST) begin
                    in_x <= '0;
                    in_y <= (in_y == Y_LAST) ? '0 : in_y + Y_ONE;
                end else begin
                    in_x <= in_x + X_ONE;
                end
            end
            if (restart) begin
                c_x <= '0;
                c_y <= '0;
            end else if (emit) begin
                if (c_x == X_LAST) begin
                    c_x <= '0;
                    c_y <= (c_y == Y_LAST) ? '0 : c_y + Y_ONE;
                end else begin
                    c_x <= c_x + X_ONE;
                end
            end
        end
    end

    // Line buffers: push the column down one line at the current x
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < IMG_W; i++) begin
                lb_a[i] <= '0;
                lb_b[i] <= '0;
            end
        end else if (step) begin
            lb_b[step_x] <= lb_a[step_x];
            lb_a[step_x] <= new_pix;
        end
    end

    // 3x3 register window shifts left by one column per step
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     win_q <= '0;
        else if (step) win_q <= nwin;
    end

    // Registered window output with border substitution
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            window_valid <= 1'b0;
            color_data   <= '0;
            win_x        <= '0;
            win_y        <= '0;
        end else begin
            window_valid <= emit;
            if (emit) begin
                color_data <= border_fix(nwin, at_l, at_r, at_t, at_b);
                win_x      <= 8'(c_x);
                win_y      <= 8'(c_y);
            end
        end
    end

endmodule
